// File: rtl/vdp_coprocessor_pkg.sv
// Shared opcode, op-word field and state definitions for the raster coprocessor.
package vdp_coprocessor_pkg;

  localparam logic [2:0] OP_SET_X  = 3'd0;
  localparam logic [2:0] OP_WAIT_Y = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_JUMP   = 3'd3;
  localparam logic [2:0] OP_HALT   = 3'd7;

  // Op word field positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int INC_BIT = 12;
  localparam int CNT_MSB = 11;
  localparam int CNT_LSB = 6;
  localparam int CNT_W   = CNT_MSB - CNT_LSB + 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_DFETCH,
    S_DWRITE,
    S_HALT
  } state_t;

endpackage

// File: rtl/vdp_raster_match.sv
// Holds the programmed beam target and flags when the beam has reached it.
// The X compare is >= so a WAIT issued late on the target line still fires.
module vdp_raster_match #(
  parameter int RASTER_X_WIDTH = 11,
  parameter int RASTER_Y_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_ld_x,
  input  logic                      i_ld_y,
  input  logic [RASTER_X_WIDTH-1:0] i_x_val,
  input  logic [RASTER_Y_WIDTH-1:0] i_y_val,
  input  logic [RASTER_X_WIDTH-1:0] i_raster_x,
  input  logic [RASTER_Y_WIDTH-1:0] i_raster_y,
  output logic                      o_hit
);

  logic [RASTER_X_WIDTH-1:0] r_tx;
  logic [RASTER_Y_WIDTH-1:0] r_ty;

  // Target registers, loaded by SET_X / WAIT_Y decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= '0;
      r_ty <= '0;
    end else begin
      if (i_ld_x) r_tx <= i_x_val;
      if (i_ld_y) r_ty <= i_y_val;
    end
  end

  assign o_hit = (i_raster_y == r_ty) && (i_raster_x >= r_tx);

endmodule

// File: rtl/vdp_raster_coprocessor.sv
// Copper-style display-list engine: fetches ops from copper RAM and issues
// beam-synchronised VDP register writes over a valid/ready port.
module vdp_raster_coprocessor
  import vdp_coprocessor_pkg::*;
#(
  parameter int PC_WIDTH       = 11,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int RASTER_X_WIDTH = 11,
  parameter int RASTER_Y_WIDTH = 10,
  parameter int PC_RESET       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      frame_restart,
  input  logic [RASTER_X_WIDTH-1:0] raster_x,
  input  logic [RASTER_Y_WIDTH-1:0] raster_y,
  output logic [PC_WIDTH-1:0]       ram_read_address,
  input  logic [15:0]               ram_read_data,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_address,
  output logic [15:0]               reg_write_data,
  output logic                      reg_write_en,
  input  logic                      reg_write_ready,
  output logic                      halted
);

  localparam logic [PC_WIDTH-1:0] LP_PC_RESET = PC_WIDTH'(PC_RESET);

  state_t                    r_state, w_state_nx;
  logic [PC_WIDTH-1:0]       r_pc, w_pc_nx;
  logic [REG_ADDR_WIDTH-1:0] r_waddr, w_waddr_nx;
  logic [15:0]               r_wdata, w_wdata_nx;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nx;
  logic                      r_wen, w_wen_nx;
  logic                      r_inc, w_inc_nx;
  logic                      r_rst_pend, w_rst_pend_nx;
  logic                      w_ld_x, w_ld_y, w_hit, w_accept;
  logic [2:0]                w_op;

  assign w_op     = ram_read_data[OP_MSB:OP_LSB];
  assign w_accept = r_wen & reg_write_ready;

  vdp_raster_match #(
    .RASTER_X_WIDTH(RASTER_X_WIDTH),
    .RASTER_Y_WIDTH(RASTER_Y_WIDTH)
  ) u_match (
    .clk       (clk),
    .reset     (reset),
    .i_ld_x    (w_ld_x),
    .i_ld_y    (w_ld_y),
    .i_x_val   (ram_read_data[RASTER_X_WIDTH-1:0]),
    .i_y_val   (ram_read_data[RASTER_Y_WIDTH-1:0]),
    .i_raster_x(raster_x),
    .i_raster_y(raster_y),
    .o_hit     (w_hit)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= LP_PC_RESET;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_wen      <= 1'b0;
      r_inc      <= 1'b0;
      r_rst_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_waddr    <= w_waddr_nx;
      r_wdata    <= w_wdata_nx;
      r_cnt      <= w_cnt_nx;
      r_wen      <= w_wen_nx;
      r_inc      <= w_inc_nx;
      r_rst_pend <= w_rst_pend_nx;
    end
  end

  // Next-state: an outstanding write owns the block until accepted; otherwise
  // restart beats everything, and enable gates normal sequencing.
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_waddr_nx    = r_waddr;
    w_wdata_nx    = r_wdata;
    w_cnt_nx      = r_cnt;
    w_wen_nx      = r_wen;
    w_inc_nx      = r_inc;
    w_rst_pend_nx = r_rst_pend;
    w_ld_x        = 1'b0;
    w_ld_y        = 1'b0;
    if (r_wen) begin
      if (w_accept) begin
        w_wen_nx = 1'b0;
        w_pc_nx  = r_pc + PC_WIDTH'(1);
        if (r_inc) w_waddr_nx = r_waddr + REG_ADDR_WIDTH'(1);
        if (frame_restart || r_rst_pend) begin
          w_pc_nx       = LP_PC_RESET;
          w_state_nx    = S_FETCH;
          w_rst_pend_nx = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_nx   = r_cnt - CNT_W'(1);
          w_state_nx = S_DFETCH;
        end else begin
          w_state_nx = S_FETCH;
        end
      end else if (frame_restart) begin
        w_rst_pend_nx = 1'b1;
      end
    end else if (frame_restart) begin
      w_pc_nx    = LP_PC_RESET;
      w_state_nx = S_FETCH;
    end else if (enable) begin
      case (r_state)
        S_FETCH:  w_state_nx = S_DECODE;
        S_DECODE: begin
          case (w_op)
            OP_SET_X: begin
              w_ld_x     = 1'b1;
              w_pc_nx    = r_pc + PC_WIDTH'(1);
              w_state_nx = S_FETCH;
            end
            OP_WAIT_Y: begin
              w_ld_y     = 1'b1;
              w_state_nx = S_WAIT;
            end
            OP_WRITE: begin
              w_inc_nx   = ram_read_data[INC_BIT];
              w_cnt_nx   = ram_read_data[CNT_MSB:CNT_LSB];
              w_waddr_nx = ram_read_data[REG_ADDR_WIDTH-1:0];
              w_pc_nx    = r_pc + PC_WIDTH'(1);
              w_state_nx = S_DFETCH;
            end
            OP_JUMP: begin
              w_pc_nx    = ram_read_data[PC_WIDTH-1:0];
              w_state_nx = S_FETCH;
            end
            OP_HALT:  w_state_nx = S_HALT;
            default: begin
              w_pc_nx    = r_pc + PC_WIDTH'(1);
              w_state_nx = S_FETCH;
            end
          endcase
        end
        S_WAIT: begin
          if (w_hit) begin
            w_pc_nx    = r_pc + PC_WIDTH'(1);
            w_state_nx = S_FETCH;
          end
        end
        S_DFETCH: w_state_nx = S_DWRITE;
        S_DWRITE: begin
          // RAM word is valid now; latch it so it stays stable under stalls
          w_wen_nx   = 1'b1;
          w_wdata_nx = ram_read_data;
        end
        S_HALT:   w_state_nx = S_HALT;
        default:  w_state_nx = S_FETCH;
      endcase
    end
  end

  assign ram_read_address  = r_pc;
  assign reg_write_address = r_waddr;
  assign reg_write_data    = r_wdata;
  assign reg_write_en      = r_wen;
  assign halted            = (r_state == S_HALT);

endmodule

// File: tb/tb_vdp_raster_coprocessor.sv
// Bench for the raster coprocessor: copper RAM model, ISA-level reference
// interpreter feeding an expected-write queue, and a decoupled write monitor.
module tb_vdp_raster_coprocessor;

  localparam int PCW = 11;
  localparam int RAW = 6;
  localparam int XW  = 11;
  localparam int YW  = 10;
  localparam int PCR = 'h010;
  localparam logic [15:0] W_HALT = 16'hE000;

  logic           clk, reset, enable, frame_restart;
  logic [XW-1:0]  raster_x;
  logic [YW-1:0]  raster_y;
  logic [PCW-1:0] ram_read_address;
  logic [15:0]    ram_read_data;
  logic [RAW-1:0] reg_write_address;
  logic [15:0]    reg_write_data;
  logic           reg_write_en, reg_write_ready, halted;

  vdp_raster_coprocessor #(
    .PC_WIDTH(PCW), .REG_ADDR_WIDTH(RAW), .RASTER_X_WIDTH(XW),
    .RASTER_Y_WIDTH(YW), .PC_RESET(PCR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_restart(frame_restart),
    .raster_x(raster_x), .raster_y(raster_y),
    .ram_read_address(ram_read_address), .ram_read_data(ram_read_data),
    .reg_write_address(reg_write_address), .reg_write_data(reg_write_data),
    .reg_write_en(reg_write_en), .reg_write_ready(reg_write_ready),
    .halted(halted)
  );

  typedef struct {
    logic [RAW-1:0] a;
    logic [15:0]    d;
    bit             need_hit;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [0:2047];
  int          errors = 0, checks = 0, n_acc = 0;
  int          rdy_mode = 0, st = 0, rx = 0, ry = 0, lp = 0;
  bit          raster_run = 0, hit_seen = 0;
  bit          pend = 0;
  logic [RAW-1:0] paddr;
  logic [15:0]    pdata;

  initial clk = 0;
  always #5 clk = ~clk;

  // copper RAM: one-cycle synchronous read
  always @(posedge clk) ram_read_data <= mem[ram_read_address];

  // ready and beam drivers, just after the active edge
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) reg_write_ready = 1'b1;
    else if (rdy_mode == 1) reg_write_ready = ($urandom_range(0, 2) != 0);
    else if (rdy_mode == 2) begin
      if (!reg_write_en) begin st = 0; reg_write_ready = 1'b0; end
      else begin st++; reg_write_ready = (st > 3); end
    end
    if (raster_run) begin
      rx = rx + $urandom_range(1, 48);
      if (rx >= 'h180) begin rx = 0; ry = (ry + 1) % 'h28; end
      raster_x = XW'(rx);
      raster_y = YW'(ry);
      if (ry == 'h20 && rx >= 'h100) hit_seen = 1;
    end
  end

  // monitor: compare every accepted write against the scoreboard
  always @(negedge clk) begin
    if (reset) pend = 0;
    else begin
      if (pend) begin
        checks++;
        if (!(reg_write_en && reg_write_address == paddr && reg_write_data == pdata)) begin
          errors++;
          $display("FAIL hold: en=%0b addr=%0h data=%0h, want en=1 addr=%0h data=%0h",
                   reg_write_en, reg_write_address, reg_write_data, paddr, pdata);
        end
      end
      if (reg_write_en && reg_write_ready) begin
        checks++;
        n_acc++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0h data=%0h, want none", reg_write_address, reg_write_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (reg_write_address != e.a || reg_write_data != e.d || (e.need_hit && !hit_seen)) begin
            errors++;
            $display("FAIL write: addr=%0h data=%0h hit_seen=%0b, want addr=%0h data=%0h hit_req=%0b",
                     reg_write_address, reg_write_data, hit_seen, e.a, e.d, e.need_hit);
          end
        end
      end
      pend  = reg_write_en && !reg_write_ready;
      paddr = reg_write_address;
      pdata = reg_write_data;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] f_setx(input int x);  return {3'd0, 13'(x)}; endfunction
  function automatic logic [15:0] f_waity(input int y); return {3'd1, 13'(y)}; endfunction
  function automatic logic [15:0] f_jump(input int a);  return {3'd3, 13'(a)}; endfunction
  function automatic logic [15:0] f_write(input int inc, input int cnt, input int rg);
    return {3'd2, 1'(inc), 6'(cnt - 1), 6'(rg)};
  endfunction

  task automatic begin_prog();
    for (int i = 0; i < 2048; i++) mem[i] = W_HALT;
    lp = PCR;
  endtask

  task automatic emit(input logic [15:0] w);
    mem[lp] = w;
    lp = (lp + 1) % 2048;
  endtask

  // Reference interpreter: walks the program at instruction level, queues the
  // register writes it implies, and totals the cycle cost with ready high and
  // every wait hitting at once.
  task automatic model_run(output int lat, output int end_pc);
    int pc, rg, n;
    bit waited, done;
    logic [15:0] w;
    exp_t e;
    pc = PCR; lat = 0; waited = 0; done = 0; end_pc = -1;
    for (int step = 0; step < 4096 && !done; step++) begin
      w = mem[pc];
      case (w[15:13])
        3'd1: begin waited = 1; pc = (pc + 1) % 2048; lat += 3; end
        3'd2: begin
          rg = int'(w[5:0]);
          n  = int'(w[11:6]) + 1;
          pc = (pc + 1) % 2048;
          for (int i = 0; i < n; i++) begin
            e.a = RAW'(rg); e.d = mem[pc]; e.need_hit = waited;
            exp_q.push_back(e);
            if (w[12]) rg = (rg + 1) % 64;
            pc = (pc + 1) % 2048;
            lat += 3;
          end
          lat += 2;
        end
        3'd3: begin pc = int'(w[10:0]); lat += 2; end
        3'd7: begin end_pc = pc; lat += 2; done = 1; end
        default: begin pc = (pc + 1) % 2048; lat += 2; end
      endcase
    end
  endtask

  task automatic start_prog(output int lat, output int end_pc);
    @(posedge clk); #1 reset = 1;
    exp_q.delete();
    model_run(lat, end_pc);
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic run_to_halt(input int bound, output int n);
    n = 0;
    while (!halted && n < bound) begin @(posedge clk); #1; n++; end
    checks++;
    if (!halted) begin errors++; $display("FAIL halt_timeout: halted=0 after %0d cycles, want 1", n); end
  endtask

  initial begin
    int lat, ep, n, base;
    reset = 1; enable = 1; frame_restart = 0; raster_x = '0; raster_y = '0;
    reg_write_ready = 0;
    begin_prog();
    repeat (2) @(posedge clk); #1;
    chk("rst_raddr", int'(ram_read_address), PCR);
    chk("rst_en", int'(reg_write_en), 0);
    chk("rst_waddr", int'(reg_write_address), 0);
    chk("rst_wdata", int'(reg_write_data), 0);
    chk("rst_halted", int'(halted), 0);

    // beam-synchronised single write, raster swept randomly
    begin_prog();
    emit(f_setx('h100)); emit(f_waity('h20)); emit(f_write(0, 1, 5)); emit(16'hBEEF); emit(W_HALT);
    rdy_mode = 1; rx = 0; ry = 0; hit_seen = 0; raster_run = 1;
    start_prog(lat, ep);
    run_to_halt(20000, n);
    chk("t1_q_empty", exp_q.size(), 0);
    raster_run = 0;

    // incrementing burst across the register-address wrap, ready stalled 3 cycles
    begin_prog();
    emit(f_write(1, 4, 'h3E));
    emit(16'h1111); emit(16'h2222); emit(16'h3333); emit(16'h4444); emit(W_HALT);
    rdy_mode = 2;
    start_prog(lat, ep);
    run_to_halt(400, n);
    chk("t2_q_empty", exp_q.size(), 0);

    // 64-word fixed-address burst, random ready
    begin_prog();
    emit(f_write(0, 64, 7));
    for (int i = 0; i < 64; i++) emit(16'($urandom));
    emit(W_HALT);
    rdy_mode = 1;
    start_prog(lat, ep);
    run_to_halt(3000, n);
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_pc", int'(ram_read_address), PCR + 65);

    // jump to top of RAM, halt, then restart
    begin_prog();
    emit(f_jump('h7FF));
    mem['h7FF] = W_HALT;
    rdy_mode = 0;
    start_prog(lat, ep);
    run_to_halt(50, n);
    chk("t4_halt_pc", int'(ram_read_address), 'h7FF);
    repeat (5) @(posedge clk); #1;
    chk("t4_halt_hold", int'(ram_read_address), 'h7FF);
    frame_restart = 1;
    @(posedge clk); #1 frame_restart = 0;
    chk("t4_restart_pc", int'(ram_read_address), PCR);
    chk("t4_restart_halted", int'(halted), 0);
    run_to_halt(50, n);

    // restart with enable low while a write is stalled on ready
    begin_prog();
    emit(f_write(0, 2, 9)); emit(16'hA5A5); emit(16'h5A5A); emit(W_HALT);
    rdy_mode = 3;
    start_prog(lat, ep);
    void'(exp_q.pop_back());
    reg_write_ready = 0;
    n = 0;
    while (!reg_write_en && n < 30) begin @(posedge clk); #1; n++; end
    chk("t5_en_up", int'(reg_write_en), 1);
    enable = 0; frame_restart = 1;
    @(posedge clk); #1 frame_restart = 0;
    repeat (4) @(posedge clk); #1;
    chk("t5_en_held", int'(reg_write_en), 1);
    reg_write_ready = 1;
    @(posedge clk); #1 reg_write_ready = 0;
    chk("t5_en_drop", int'(reg_write_en), 0);
    chk("t5_pc_reset", int'(ram_read_address), PCR);
    repeat (6) @(posedge clk); #1;
    chk("t5_frozen_pc", int'(ram_read_address), PCR);
    chk("t5_q_empty", exp_q.size(), 0);
    model_run(lat, ep);
    rdy_mode = 0; enable = 1;
    run_to_halt(200, n);
    chk("t5_rerun_q_empty", exp_q.size(), 0);

    // async reset in the middle of a burst
    begin_prog();
    emit(f_write(1, 8, 'h10));
    for (int i = 0; i < 8; i++) emit(16'($urandom));
    emit(W_HALT);
    rdy_mode = 0;
    start_prog(lat, ep);
    base = n_acc; n = 0;
    while (n_acc < base + 3 && n < 200) begin @(posedge clk); n++; end
    chk("t6_progress", int'(n_acc >= base + 3), 1);
    #3 reset = 1;
    #1;
    chk("t6_rst_en", int'(reg_write_en), 0);
    chk("t6_rst_waddr", int'(reg_write_address), 0);
    chk("t6_rst_wdata", int'(reg_write_data), 0);
    chk("t6_rst_raddr", int'(ram_read_address), PCR);
    exp_q.delete();
    model_run(lat, ep);
    @(posedge clk); #1 reset = 0;
    run_to_halt(200, n);
    chk("t6_q_empty", exp_q.size(), 0);

    // latency with ready high; target X already passed on the target line
    begin_prog();
    emit(16'h8000); emit(f_setx('h100)); emit(f_waity(5));
    emit(f_write(0, 2, 1)); emit(16'($urandom)); emit(16'($urandom)); emit(W_HALT);
    raster_run = 0; raster_x = XW'('h300); raster_y = YW'(5); hit_seen = 1; rdy_mode = 0;
    start_prog(lat, ep);
    run_to_halt(200, n);
    chk("t7_latency", n, lat);
    chk("t7_q_empty", exp_q.size(), 0);

    // random straight-line programs
    for (int it = 0; it < 4; it++) begin
      begin_prog();
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 2))
          0: emit({3'($urandom_range(4, 6)), 13'($urandom)});
          1: emit(f_setx($urandom_range(0, 2047)));
          default: begin
            int c;
            c = $urandom_range(1, 6);
            emit(f_write($urandom_range(0, 1), c, $urandom_range(0, 63)));
            for (int i = 0; i < c; i++) emit(16'($urandom));
          end
        endcase
      end
      emit(W_HALT);
      rdy_mode = 1;
      start_prog(lat, ep);
      run_to_halt(3000, n);
      chk("rand_q_empty", exp_q.size(), 0);
      chk("rand_halt_pc", int'(ram_read_address), ep);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
